// File: rtl/oam_dma_ctrl_if.sv
// CPU-side snoop signals and arbitrated system-bus signals of the sprite-DMA controller.
// slave = the controller; master = the CPU/bus environment around it.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_r_nw;
  logic [7:0]  bus_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_r_nw;
  logic        cpu_rdy;
  logic        dma_active;
  logic        dma_done;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_r_nw, bus_din,
    output bus_addr, bus_dout, bus_r_nw, cpu_rdy, dma_active, dma_done
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_r_nw, bus_din,
    input  bus_addr, bus_dout, bus_r_nw, cpu_rdy, dma_active, dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA bus controller: snoops CPU writes to the DMA register, stalls the CPU via RDY,
// then copies one 256-byte page to the OAM data port as alternating read/write cycles.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic          i_clk_ph1,
  input  logic          i_rst,
  oam_dma_ctrl_if.slave dma_if
);
  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t     r_state;
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic [7:0] r_data;
  logic       r_parity;
  logic       r_done;

  logic w_trigger;
  logic w_dma_rd;
  logic w_dma_wr;

  assign w_trigger = !dma_if.cpu_r_nw && (dma_if.cpu_addr == DMA_REG_ADDR);
  assign w_dma_rd  = (r_state == S_READ);
  assign w_dma_wr  = (r_state == S_WRITE);

  always_ff @(posedge i_clk_ph1 or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_idx    <= 8'h00;
      r_page   <= 8'h00;
      r_data   <= 8'h00;
      r_parity <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_page  <= dma_if.cpu_dout;
            r_idx   <= 8'h00;
            r_state <= S_HALT;
          end
        end
        // The 6502 only honours RDY on a read cycle, so wait for one before taking the bus.
        S_HALT: begin
          if (dma_if.cpu_r_nw) begin
            r_state <= r_parity ? S_READ : S_ALIGN;
          end
        end
        S_ALIGN: begin
          r_state <= S_READ;
        end
        S_READ: begin
          r_data  <= dma_if.bus_din;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_idx <= r_idx + 8'h01;
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_READ;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus mux is steered by the state register alone; the CPU keeps the bus in every other state.
  always_comb begin
    dma_if.bus_addr = dma_if.cpu_addr;
    dma_if.bus_dout = dma_if.cpu_dout;
    dma_if.bus_r_nw = dma_if.cpu_r_nw;
    if (w_dma_rd) begin
      dma_if.bus_addr = {r_page, r_idx};
      dma_if.bus_r_nw = 1'b1;
    end else if (w_dma_wr) begin
      dma_if.bus_addr = OAM_DATA_ADDR;
      dma_if.bus_dout = r_data;
      dma_if.bus_r_nw = 1'b0;
    end
  end

  assign dma_if.cpu_rdy    = (r_state == S_IDLE);
  assign dma_if.dma_active = w_dma_rd | w_dma_wr;
  assign dma_if.dma_done   = r_done;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: table-driven and random transfers checked against a page-copy model,
// plus hand-written reset-abort, ignored-retrigger and back-to-back sequences.
module tb_oam_dma_ctrl;
  logic clk;
  logic rst_n;
  logic [7:0] mem_key;

  oam_dma_ctrl_if u_if ();

  oam_dma_ctrl u_dut (
    .i_clk_ph1 (clk),
    .i_rst     (rst_n),
    .dma_if    (u_if)
  );

  // System memory: byte at address a is a[7:0] ^ mem_key.
  assign u_if.bus_din = u_if.bus_addr[7:0] ^ mem_key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; its LSB is the get/put parity.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    else pass_cnt++;
  endtask

  // Bus monitor, sampled on the falling edge.
  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  int low_cnt, done_cnt, done_cyc, first_rd, pass_err, zero_hits;
  logic last_rdy;

  task automatic clear_logs();
    rd_q.delete();
    wr_q.delete();
    low_cnt = 0; done_cnt = 0; done_cyc = -1; first_rd = -1; pass_err = 0; zero_hits = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      last_rdy = u_if.cpu_rdy;
      if (!u_if.cpu_rdy) low_cnt++;
      if (u_if.dma_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!u_if.dma_active) begin
        if (u_if.bus_addr !== u_if.cpu_addr || u_if.bus_dout !== u_if.cpu_dout ||
            u_if.bus_r_nw !== u_if.cpu_r_nw) pass_err++;
      end else begin
        if (u_if.cpu_rdy) pass_err++;
        if (u_if.bus_r_nw) begin
          if (rd_q.size() == 0) first_rd = cyc;
          rd_q.push_back(u_if.bus_addr);
          if (u_if.bus_addr == 16'h0000) zero_hits++;
        end else if (u_if.bus_addr == 16'h2004) begin
          wr_q.push_back(u_if.bus_dout);
        end else begin
          pass_err++;
        end
      end
    end
  end

  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    u_if.cpu_addr = a;
    u_if.cpu_dout = d;
    u_if.cpu_r_nw = rnw;
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the transfer in flight.
  int exp_fr;
  int exp_low_m;

  // HALT-phase CPU writes followed by the first CPU read; model predicts alignment and stall length.
  task automatic tail(input int w);
    int c_r;
    int a;
    for (int k = 0; k < w; k++) step(16'h01FD - 16'(k), 8'($urandom), 1'b0);
    c_r = cyc;
    a = (c_r % 2 == 0) ? 1 : 0;
    exp_fr = c_r + 1 + a;
    exp_low_m = (w + 1) + a + 2 * 256;
    step(16'hC000, 8'h00, 1'b1);
  endtask

  task automatic begin_xfer(input logic [7:0] page, input int w, input int par);
    while (((cyc + 1 + w) % 2) != par) step(16'h8000, 8'h00, 1'b1);
    clear_logs();
    step(16'h4014, page, 1'b0);
    tail(w);
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      step(16'hC000, 8'h00, 1'b1);
      guard++;
    end while (!last_rdy && guard < 1500);
    chk("returned_to_idle", 32'(last_rdy), 32'd1);
  endtask

  task automatic check_xfer(input logic [7:0] page, input logic [7:0] key, input int exp_low);
    int bad_r = 0;
    int bad_w = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < rd_q.size() && rd_q[i] !== {page, 8'(i)}) bad_r++;
      if (i < wr_q.size() && wr_q[i] !== (8'(i) ^ key)) bad_w++;
    end
    chk("cpu_rdy_low_cycles", 32'(low_cnt), 32'(exp_low));
    chk("first_read_cycle", 32'(first_rd), 32'(exp_fr));
    chk("read_count", 32'(rd_q.size()), 32'd256);
    chk("oam_write_count", 32'(wr_q.size()), 32'd256);
    chk("read_addr_mismatches", 32'(bad_r), 32'd0);
    chk("oam_data_mismatches", 32'(bad_w), 32'd0);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_cycle", 32'(done_cyc), 32'(exp_fr + 512));
    chk("bus_rule_errors", 32'(pass_err), 32'd0);
    if (page == 8'hFF) chk("page_ff_zero_access", 32'(zero_hits), 32'd0);
  endtask

  typedef struct {
    logic [7:0] page;
    int         w;
    int         par;
    logic [7:0] key;
    int         exp_low;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nw;
    int g;
    logic [7:0] pg;
    int w;
    int par;

    vecs[0] = '{8'h02, 0, 0, 8'h5A, 514};
    vecs[1] = '{8'h02, 0, 1, 8'h5A, 513};
    vecs[2] = '{8'h02, 2, 1, 8'h33, 515};
    vecs[3] = '{8'h02, 2, 0, 8'h33, 516};
    vecs[4] = '{8'hFF, 0, 0, 8'hA5, 514};
    vecs[5] = '{8'h00, 1, 1, 8'hC3, 514};

    rst_n = 1'b0;
    mem_key = 8'h00;
    u_if.cpu_addr = 16'h1234;
    u_if.cpu_dout = 8'h56;
    u_if.cpu_r_nw = 1'b0;
    clear_logs();
    last_rdy = 1'b0;
    #3;
    chk("reset_cpu_rdy", 32'(u_if.cpu_rdy), 32'd1);
    chk("reset_dma_active", 32'(u_if.dma_active), 32'd0);
    chk("reset_dma_done", 32'(u_if.dma_done), 32'd0);
    chk("reset_bus_addr", 32'(u_if.bus_addr), 32'h1234);
    chk("reset_bus_dout", 32'(u_if.bus_dout), 32'h56);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      mem_key = vecs[v].key;
      begin_xfer(vecs[v].page, vecs[v].w, vecs[v].par);
      wait_idle();
      check_xfer(vecs[v].page, vecs[v].key, vecs[v].exp_low);
    end

    for (int r = 0; r < 5; r++) begin
      pg = 8'($urandom);
      w = $urandom_range(0, 3);
      par = $urandom_range(0, 1);
      mem_key = 8'($urandom);
      begin_xfer(pg, w, par);
      wait_idle();
      check_xfer(pg, mem_key, exp_low_m);
    end

    // Retrigger attempt mid-transfer must leave the page alone.
    mem_key = 8'h17;
    begin_xfer(8'h02, 0, 1);
    repeat (50) step(16'hC000, 8'h00, 1'b1);
    step(16'h4014, 8'h03, 1'b0);
    wait_idle();
    check_xfer(8'h02, 8'h17, exp_low_m);

    // Back-to-back: trigger lands in the dma_done cycle.
    mem_key = 8'h6C;
    begin_xfer(8'h02, 0, 0);
    g = 0;
    while (cyc < exp_fr + 512 && g < 1000) begin
      step(16'hC000, 8'h00, 1'b1);
      g++;
    end
    step(16'h4014, 8'h05, 1'b0);
    check_xfer(8'h02, 8'h6C, 514);
    clear_logs();
    tail(0);
    wait_idle();
    check_xfer(8'h05, 8'h6C, exp_low_m);

    // Reset abort after 100 OAM writes.
    mem_key = 8'h99;
    begin_xfer(8'h02, 0, 0);
    g = 0;
    while (wr_q.size() < 100 && g < 400) begin
      step(16'hC000, 8'h00, 1'b1);
      g++;
    end
    chk("writes_before_reset", 32'(wr_q.size()), 32'd100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_cpu_rdy", 32'(u_if.cpu_rdy), 32'd1);
    chk("abort_dma_active", 32'(u_if.dma_active), 32'd0);
    chk("abort_dma_done", 32'(u_if.dma_done), 32'd0);
    chk("abort_bus_addr", 32'(u_if.bus_addr), 32'hC000);
    chk("abort_bus_r_nw", 32'(u_if.bus_r_nw), 32'd1);
    nw = wr_q.size();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (40) step(16'hC000, 8'h00, 1'b1);
    chk("post_reset_oam_writes", 32'(wr_q.size()), 32'(nw));
    chk("post_reset_done", 32'(done_cnt), 32'd0);
    chk("post_reset_rdy", 32'(last_rdy), 32'd1);
    begin_xfer(8'h04, 1, 0);
    wait_idle();
    check_xfer(8'h04, 8'h99, exp_low_m);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
